// File: rtl/kypd_scan_ctrl.sv
// Column scan sequencer and debouncer for the 4x4 PmodKYPD.
// Emits one key-press event per accepted press through a single-entry valid/ready buffer.
module kypd_scan_ctrl #(
    parameter int COL_PERIOD     = 100000,
    parameter int SETTLE         = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int CNT_W = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(COL_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
    localparam logic [DB_W-1:0]  DB_FULL    = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_EVAL
    } state_t;

    state_t             state, state_next;
    logic [1:0]         col_idx, col_idx_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [3:0]         col_next;
    logic [3:0][3:0]    row_s;

    logic               res_found, res_multi;
    logic [3:0]         res_code;

    logic               cand_key, cand_key_next;
    logic [3:0]         cand_code, cand_code_next;
    logic [DB_W-1:0]    db_cnt, db_cnt_next;
    logic               stable_key, stable_key_next;
    logic [3:0]         stable_code, stable_code_next;
    logic               evt;

    // Key legend indexed by column (0 = C1) and row (0 = R1).
    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        case ({c, r})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h4;
            4'b00_10: k = 4'h7;
            4'b00_11: k = 4'h0;
            4'b01_00: k = 4'h2;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h8;
            4'b01_11: k = 4'hF;
            4'b10_00: k = 4'h3;
            4'b10_01: k = 4'h6;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hE;
            4'b11_00: k = 4'hA;
            4'b11_01: k = 4'hB;
            4'b11_10: k = 4'hC;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            col_idx <= 2'd0;
            cnt     <= '0;
            Col     <= 4'b1111;
        end else begin
            state   <= state_next;
            col_idx <= col_idx_next;
            cnt     <= cnt_next;
            Col     <= col_next;
        end
    end

    always_comb begin
        state_next   = state;
        col_idx_next = col_idx;
        cnt_next     = cnt;
        col_next     = Col;
        case (state)
            S_IDLE: begin
                state_next   = S_DRIVE;
                col_idx_next = 2'd0;
                cnt_next     = '0;
                col_next     = 4'b0111;
            end
            S_DRIVE: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (col_idx == 2'd3) begin
                        state_next = S_EVAL;
                        col_next   = 4'b1111;
                    end else begin
                        col_idx_next = col_idx + 2'd1;
                        col_next     = ~(4'b1000 >> (col_idx + 2'd1));
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next   = S_DRIVE;
                col_idx_next = 2'd0;
                cnt_next     = '0;
                col_next     = 4'b0111;
            end
        endcase
    end

    // Row is captured once per column, SETTLE cycles after the column changed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s <= '1;
        end else if (state == S_DRIVE && cnt == CNT_SETTLE) begin
            row_s[col_idx] <= Row;
        end
    end

    always_comb begin
        res_found = 1'b0;
        res_multi = 1'b0;
        res_code  = 4'h0;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (!row_s[c][b]) begin
                    if (res_found) res_multi = 1'b1;
                    res_found = 1'b1;
                    res_code  = key_map(2'(c), 2'(3 - b));
                end
            end
        end
    end

    // MULTI scans leave the debouncer untouched; NONE is tracked like a key.
    always_comb begin
        cand_key_next    = cand_key;
        cand_code_next   = cand_code;
        db_cnt_next      = db_cnt;
        stable_key_next  = stable_key;
        stable_code_next = stable_code;
        evt              = 1'b0;
        if (state == S_EVAL && !res_multi) begin
            if (res_found == cand_key && (!res_found || res_code == cand_code)) begin
                if (db_cnt != DB_FULL) db_cnt_next = db_cnt + DB_ONE;
            end else begin
                cand_key_next  = res_found;
                cand_code_next = res_found ? res_code : 4'h0;
                db_cnt_next    = DB_ONE;
            end
            if (db_cnt_next == DB_FULL) begin
                stable_key_next  = cand_key_next;
                stable_code_next = cand_code_next;
                if (cand_key_next && (!stable_key || stable_code != cand_code_next)) evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_key    <= 1'b0;
            cand_code   <= 4'h0;
            db_cnt      <= '0;
            stable_key  <= 1'b0;
            stable_code <= 4'h0;
        end else begin
            cand_key    <= cand_key_next;
            cand_code   <= cand_code_next;
            db_cnt      <= db_cnt_next;
            stable_key  <= stable_key_next;
            stable_code <= stable_code_next;
        end
    end

    assign key_held = stable_key;

    // A new event may replace an entry that is being accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (evt && (!key_valid || key_ready)) begin
                key_code  <= stable_code_next;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (evt && key_valid && !key_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Bench for kypd_scan_ctrl: keypad row model driven by Col, event scoreboard on the handshake.
module tb_kypd_scan_ctrl;

    localparam int COL_PERIOD     = 16;
    localparam int SETTLE         = 2;
    localparam int DEBOUNCE_SCANS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        overrun;
    logic        overrun_clr;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    kypd_scan_ctrl #(
        .COL_PERIOD    (COL_PERIOD),
        .SETTLE        (SETTLE),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Row        (Row),
        .Col        (Col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_held   (key_held),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    // Returns {column, row} of a key, column 0 = C1, row 0 = R1.
    function automatic logic [3:0] key_pos(input int code);
        case (code)
            1:  return 4'b00_00;
            4:  return 4'b00_01;
            7:  return 4'b00_10;
            0:  return 4'b00_11;
            2:  return 4'b01_00;
            5:  return 4'b01_01;
            8:  return 4'b01_10;
            15: return 4'b01_11;
            3:  return 4'b10_00;
            6:  return 4'b10_01;
            9:  return 4'b10_10;
            14: return 4'b10_11;
            10: return 4'b11_00;
            11: return 4'b11_01;
            12: return 4'b11_10;
            default: return 4'b11_11;
        endcase
    endfunction

    always_comb begin
        logic [3:0] pos;
        pos = 4'h0;
        Row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k]) begin
                pos = key_pos(k);
                if (Col[3 - pos[3:2]] == 1'b0) Row[3 - pos[1:0]] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got key_code %h, no event expected", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp) begin
                    errors++;
                    $display("FAIL evt_code: got %h, expected %h", key_code, mon_exp);
                end
            end
        end
    end

    task automatic wait_eval();
        int n = 0;
        while (Col !== 4'b1111 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL eval_timeout: Col %b, expected 1111 within 200 cycles", Col);
        end
    endtask

    task automatic scan_end();
        wait_eval();
        @(posedge clk); #1;
    endtask

    task automatic scans(input int n);
        repeat (n) scan_end();
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst_n = 1'b0; key_ready = 1'b1; overrun_clr = 1'b0; pressed = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (Col !== 4'b1111 || key_valid !== 1'b0 || key_code !== 4'h0 ||
            key_held !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: Col=%b valid=%b code=%h held=%b ovr=%b, expected 1111 0 0 0 0",
                     Col, key_valid, key_code, key_held, overrun);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(posedge clk); #1;
            if (i < 64)       exp_col = ~(4'b1000 >> (i / 16));
            else if (i == 64) exp_col = 4'b1111;
            else              exp_col = 4'b0111;
            checks++;
            if (Col !== exp_col) begin
                errors++;
                $display("FAIL scan_order[%0d]: Col=%b, expected %b", i, Col, exp_col);
            end
        end
    endtask

    task automatic test_key_hold();
        pressed = 16'h1 << 6;
        exp_q.push_back(4'h6);
        scan_end();
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL hold_scan1: valid=%b held=%b, expected 0 0", key_valid, key_held);
        end
        scan_end();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h6 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL hold_event: valid=%b code=%h held=%b, expected 1 6 1", key_valid, key_code, key_held);
        end
        @(posedge clk); #1;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_pulse: valid=%b, expected 0", key_valid);
        end
        scans(3);
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL hold_steady: valid=%b held=%b, expected 0 1", key_valid, key_held);
        end
        pressed = 16'h0;
        scan_end();
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL release_scan1: held=%b, expected 1", key_held);
        end
        scan_end();
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL release_scan2: held=%b, expected 0", key_held);
        end
    endtask

    task automatic test_glitch();
        pressed = 16'h1 << 9;
        scan_end();
        pressed = 16'h0;
        scans(2);
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL glitch: valid=%b held=%b, expected 0 0", key_valid, key_held);
        end
    endtask

    task automatic test_multi();
        pressed = (16'h1 << 5) | (16'h1 << 9);
        scans(5);
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL multi_ignored: valid=%b held=%b, expected 0 0", key_valid, key_held);
        end
        pressed = 16'h1 << 9;
        exp_q.push_back(4'h9);
        scan_end();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_single1: valid=%b, expected 0", key_valid);
        end
        scan_end();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h9 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL multi_event: valid=%b code=%h held=%b, expected 1 9 1", key_valid, key_code, key_held);
        end
        pressed = 16'h0;
        scans(2);
    endtask

    task automatic test_overrun();
        key_ready = 1'b0;
        pressed = 16'h1 << 1;
        exp_q.push_back(4'h1);
        scans(2);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h1) begin
            errors++;
            $display("FAIL ovr_first: valid=%b code=%h, expected 1 1", key_valid, key_code);
        end
        pressed = 16'h0;
        scans(2);
        pressed = 16'h1 << 15;
        scans(2);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h1 || overrun !== 1'b1 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: valid=%b code=%h ovr=%b held=%b, expected 1 1 1 1",
                     key_valid, key_code, overrun, key_held);
        end
        key_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (key_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_accept: valid=%b ovr=%b, expected 0 1", key_valid, overrun);
        end
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b, expected 0", overrun);
        end
        pressed = 16'h0;
        scans(2);
    endtask

    task automatic test_back_to_back();
        key_ready = 1'b0;
        pressed = 16'h1 << 10;
        exp_q.push_back(4'hA);
        scans(2);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'hA) begin
            errors++;
            $display("FAIL b2b_first: valid=%b code=%h, expected 1 a", key_valid, key_code);
        end
        pressed = 16'h1 << 12;
        exp_q.push_back(4'hC);
        scan_end();
        wait_eval();
        key_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'hC || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload: valid=%b code=%h ovr=%b, expected 1 c 0", key_valid, key_code, overrun);
        end
        @(posedge clk); #1;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, expected 0", key_valid);
        end
        pressed = 16'h0;
        scans(2);
    endtask

    task automatic test_reset_pending();
        key_ready = 1'b0;
        pressed = 16'h1 << 6;
        scans(2);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h6) begin
            errors++;
            $display("FAIL pend_event: valid=%b code=%h, expected 1 6", key_valid, key_code);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (key_valid !== 1'b0 || key_code !== 4'h0 || key_held !== 1'b0 || Col !== 4'b1111) begin
            errors++;
            $display("FAIL pend_reset: valid=%b code=%h held=%b Col=%b, expected 0 0 0 1111",
                     key_valid, key_code, key_held, Col);
        end
        pressed = 16'h0;
        key_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (Col !== 4'b0111) begin
            errors++;
            $display("FAIL pend_restart: Col=%b, expected 0111", Col);
        end
        scans(2);
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL pend_discard: valid=%b held=%b, expected 0 0", key_valid, key_held);
        end
    endtask

    initial begin
        test_reset();
        test_key_hold();
        test_glitch();
        test_multi();
        test_overrun();
        test_back_to_back();
        test_reset_pending();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL events_missing: %0d expected events not seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
